// File: rtl/midi_pkg.sv
// Shared MIDI constants, allocator FSM states and event record types.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_PRESS = 4'hA;
    localparam logic [3:0] CTRL       = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;
    localparam logic [3:0] PITCH      = 4'hE;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLookup,
        StResolve,
        StEmit
    } alloc_state_e;

    typedef struct packed {
        logic [6:0] note;
        logic [6:0] velocity;
        logic [3:0] channel;
        logic [7:0] addr;
    } evt_fields_t;

    typedef struct packed {
        logic pressed;
        logic released;
        logic keypress;
        logic pitch;
        logic exhausted;
        logic overflow;
    } evt_pulse_t;

    // Data bytes carried by a channel message; 0 means no running status.
    function automatic logic [1:0] data_len(input logic [3:0] status);
        case (status)
            NOTE_OFF, NOTE_ON, POLY_PRESS, CTRL, PITCH: data_len = 2'd2;
            PROG, CHAN_PRESS:                           data_len = 2'd1;
            default:                                    data_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/voice_free_fifo.sv
// Free-slot FIFO; a push is taken when full only if a pop frees room in the same cycle.
module voice_free_fifo #(
    parameter int unsigned DEPTH = 256
) (
    input  logic       clk96,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk96 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk96) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI voice allocator: parses a byte stream and maps note events onto voice slots
// through a {channel, note} map and a free-slot FIFO.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES   = 256,
    parameter int unsigned NUM_CHANNELS = 16
) (
    input  logic       clk96,
    input  logic       rst_n,
    input  logic [7:0] midi_byte,
    input  logic       midi_byte_valid,
    output logic       byte_ready,
    input  logic       voice_free,
    input  logic [7:0] voice_free_addr,
    output logic       note_pressed,
    output logic       note_released,
    output logic       note_keypress,
    output logic       pitch_wheel,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic [7:0] addr,
    output logic       voices_exhausted,
    output logic       free_overflow
);
    localparam int unsigned MAP_DEPTH   = NUM_CHANNELS * 128;
    localparam int unsigned MAP_AW      = $clog2(MAP_DEPTH);
    localparam int unsigned CH_W        = MAP_AW - 7;
    localparam int unsigned INIT_CYCLES = (MAP_DEPTH > NUM_VOICES) ? MAP_DEPTH : NUM_VOICES;
    localparam int unsigned CNT_W       = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAP_END   = CNT_W'(MAP_DEPTH);
    localparam logic [CNT_W-1:0] VOICE_END = CNT_W'(NUM_VOICES);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    alloc_state_e      state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [3:0]        rs_q, rs_d, rs_chan_q, rs_chan_d;
    logic              have_d1_q, have_d1_d;
    logic [6:0]        d1_q, d1_d;
    logic [3:0]        msg_kind_q, msg_kind_d, msg_chan_q, msg_chan_d;
    logic [6:0]        msg_note_q, msg_note_d, msg_val_q, msg_val_d;
    evt_fields_t       fields_q, fields_d;
    evt_pulse_t        pulse_q, pulse_d;

    logic [8:0]        map_mem [MAP_DEPTH];
    logic [8:0]        map_rdata_q, map_wdata;
    logic [MAP_AW-1:0] map_raddr, map_waddr;
    logic              map_we;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_push_data, fifo_pop_data;
    logic              accept, chan_tracked, resolve_emit;
    logic [7:0]        resolve_slot;

    voice_free_fifo #(
        .DEPTH(NUM_VOICES)
    ) u_free_fifo (
        .clk96    (clk96),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .pop_data (fifo_pop_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign byte_ready   = (state_q == StIdle);
    assign accept       = midi_byte_valid && byte_ready;
    assign chan_tracked = (32'(rs_chan_q) < NUM_CHANNELS);
    assign map_raddr    = {msg_chan_q[CH_W-1:0], msg_note_q};

    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        rs_d           = rs_q;
        rs_chan_d      = rs_chan_q;
        have_d1_d      = have_d1_q;
        d1_d           = d1_q;
        msg_kind_d     = msg_kind_q;
        msg_chan_d     = msg_chan_q;
        msg_note_d     = msg_note_q;
        msg_val_d      = msg_val_q;
        fields_d       = fields_q;
        pulse_d        = '0;
        map_we         = 1'b0;
        map_waddr      = map_raddr;
        map_wdata      = '0;
        fifo_push      = voice_free && (state_q != StInit);
        fifo_push_data = voice_free_addr;
        fifo_pop       = 1'b0;
        resolve_emit   = 1'b0;
        resolve_slot   = map_rdata_q[7:0];

        case (state_q)
            StInit: begin
                map_we         = (init_cnt_q < MAP_END);
                map_waddr      = MAP_AW'(init_cnt_q);
                fifo_push      = (init_cnt_q < VOICE_END);
                fifo_push_data = 8'(init_cnt_q);
                if (init_cnt_q == INIT_LAST) state_d = StIdle;
                else                         init_cnt_d = init_cnt_q + 1'b1;
            end
            StIdle: begin
                if (accept) begin
                    if (midi_byte[7]) begin
                        // Realtime bytes (F8-FF) leave running status and data untouched.
                        if (midi_byte[7:4] != 4'hF) begin
                            rs_d      = midi_byte[7:4];
                            rs_chan_d = midi_byte[3:0];
                            have_d1_d = 1'b0;
                        end else if (!midi_byte[3]) begin
                            rs_d      = 4'h0;
                            have_d1_d = 1'b0;
                        end
                    end else if (data_len(rs_q) == 2'd2) begin
                        if (!have_d1_q) begin
                            d1_d      = midi_byte[6:0];
                            have_d1_d = 1'b1;
                        end else begin
                            have_d1_d  = 1'b0;
                            msg_chan_d = rs_chan_q;
                            msg_note_d = d1_q;
                            msg_val_d  = midi_byte[6:0];
                            msg_kind_d = (rs_q == NOTE_ON && midi_byte[6:0] == 7'd0) ?
                                         NOTE_OFF : rs_q;
                            if (rs_q == PITCH) begin
                                pulse_d.pitch     = 1'b1;
                                fields_d.note     = midi_byte[6:0];
                                fields_d.velocity = d1_q;
                                fields_d.channel  = rs_chan_q;
                                state_d           = StEmit;
                            end else if (rs_q != CTRL && chan_tracked) begin
                                state_d = StLookup;
                            end
                        end
                    end
                end
            end
            StLookup: state_d = StResolve;
            StResolve: begin
                state_d = StEmit;
                case (msg_kind_q)
                    NOTE_ON: begin
                        if (map_rdata_q[8]) begin
                            resolve_emit    = 1'b1;
                            pulse_d.pressed = 1'b1;
                        end else if (!fifo_empty) begin
                            fifo_pop        = 1'b1;
                            map_we          = 1'b1;
                            map_wdata       = {1'b1, fifo_pop_data};
                            resolve_emit    = 1'b1;
                            resolve_slot    = fifo_pop_data;
                            pulse_d.pressed = 1'b1;
                        end else begin
                            pulse_d.exhausted = 1'b1;
                        end
                    end
                    NOTE_OFF: begin
                        if (map_rdata_q[8]) begin
                            map_we           = 1'b1;
                            resolve_emit     = 1'b1;
                            pulse_d.released = 1'b1;
                        end
                    end
                    POLY_PRESS: begin
                        if (map_rdata_q[8]) begin
                            resolve_emit     = 1'b1;
                            pulse_d.keypress = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (resolve_emit) fields_d = {msg_note_q, msg_val_q, msg_chan_q, resolve_slot};
            end
            StEmit:  state_d = StIdle;
            default: state_d = StInit;
        endcase

        pulse_d.overflow = voice_free && (state_q != StInit) && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk96 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            rs_q       <= '0;
            rs_chan_q  <= '0;
            have_d1_q  <= 1'b0;
            d1_q       <= '0;
            msg_kind_q <= '0;
            msg_chan_q <= '0;
            msg_note_q <= '0;
            msg_val_q  <= '0;
            fields_q   <= '0;
            pulse_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rs_q       <= rs_d;
            rs_chan_q  <= rs_chan_d;
            have_d1_q  <= have_d1_d;
            d1_q       <= d1_d;
            msg_kind_q <= msg_kind_d;
            msg_chan_q <= msg_chan_d;
            msg_note_q <= msg_note_d;
            msg_val_q  <= msg_val_d;
            fields_q   <= fields_d;
            pulse_q    <= pulse_d;
        end
    end

    always_ff @(posedge clk96) begin
        if (map_we) map_mem[map_waddr] <= map_wdata;
        map_rdata_q <= map_mem[map_raddr];
    end

    assign note_pressed     = pulse_q.pressed;
    assign note_released    = pulse_q.released;
    assign note_keypress    = pulse_q.keypress;
    assign pitch_wheel      = pulse_q.pitch;
    assign voices_exhausted = pulse_q.exhausted;
    assign free_overflow    = pulse_q.overflow;
    assign note             = fields_q.note;
    assign velocity         = fields_q.velocity;
    assign channel          = fields_q.channel;
    assign addr             = fields_q.addr;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: spec-level model with per-cycle compare plus literal checks.
module tb_midi_voice_alloc;
    localparam int NV = 256;

    logic       clk96, rst_n;
    logic [7:0] midi_byte;
    logic       midi_byte_valid, byte_ready;
    logic       voice_free;
    logic [7:0] voice_free_addr;
    logic       note_pressed, note_released, note_keypress, pitch_wheel;
    logic [6:0] note, velocity;
    logic [3:0] channel;
    logic [7:0] addr;
    logic       voices_exhausted, free_overflow;

    midi_voice_alloc #(.NUM_VOICES(256), .NUM_CHANNELS(16)) dut (
        .clk96           (clk96),
        .rst_n           (rst_n),
        .midi_byte       (midi_byte),
        .midi_byte_valid (midi_byte_valid),
        .byte_ready      (byte_ready),
        .voice_free      (voice_free),
        .voice_free_addr (voice_free_addr),
        .note_pressed    (note_pressed),
        .note_released   (note_released),
        .note_keypress   (note_keypress),
        .pitch_wheel     (pitch_wheel),
        .note            (note),
        .velocity        (velocity),
        .channel         (channel),
        .addr            (addr),
        .voices_exhausted(voices_exhausted),
        .free_overflow   (free_overflow)
    );

    // kind: 0 pressed, 1 released, 2 keypress, 3 pitch, 4 exhausted, 5 overflow
    typedef struct {
        int         due;
        int         kind;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] chan;
        logic [7:0] addr;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] free_q[$];
    bit         m_valid [2048];
    logic [7:0] m_slot  [2048];
    logic [3:0] m_rs, m_ch;
    bit         m_have;
    logic [6:0] m_d1;
    logic [7:0] m_addr;

    int         checks = 0, passed = 0, cyc = 0;
    bit         chk_en = 0;
    int         last_cyc, last_acc, pulse_cnt = 0, pc;
    logic [5:0] last_vec, cmp_got, cmp_want;
    logic [25:0] last_fields;
    ev_t        cmp_ev;
    bit         cmp_have;

    initial begin
        clk96 = 0;
        forever #5 clk96 = ~clk96;
    end

    always @(posedge clk96) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endtask

    task automatic model_reset();
        m_rs = 4'h0; m_ch = 4'h0; m_have = 0; m_d1 = '0; m_addr = '0;
        for (int i = 0; i < 2048; i++) begin
            m_valid[i] = 0;
            m_slot[i]  = '0;
        end
        free_q.delete();
        for (int i = 0; i < NV; i++) free_q.push_back(8'(i));
        exp_q.delete();
    endtask

    task automatic model_msg(input logic [3:0] st, input logic [3:0] ch, input logic [6:0] d1,
                             input logic [6:0] d2, input int acc);
        ev_t ev;
        int  idx;
        idx = int'(ch) * 128 + int'(d1);
        ev.chan = ch; ev.note = d1; ev.vel = d2; ev.due = acc + 3; ev.addr = '0;
        if (st == 4'hE) begin
            ev.kind = 3; ev.note = d2; ev.vel = d1; ev.addr = m_addr; ev.due = acc + 1;
            exp_q.push_back(ev);
            return;
        end
        if (st == 4'h9 && d2 != 7'd0) begin
            ev.kind = 0;
            if (m_valid[idx]) ev.addr = m_slot[idx];
            else if (free_q.size() > 0) begin
                ev.addr = free_q.pop_front();
                m_valid[idx] = 1;
                m_slot[idx]  = ev.addr;
            end else begin
                ev.kind = 4;
                exp_q.push_back(ev);
                return;
            end
        end else if (st == 4'h8 || st == 4'h9) begin
            if (!m_valid[idx]) return;
            ev.kind = 1; ev.addr = m_slot[idx]; m_valid[idx] = 0;
        end else if (st == 4'hA) begin
            if (!m_valid[idx]) return;
            ev.kind = 2; ev.addr = m_slot[idx];
        end else return;
        m_addr = ev.addr;
        exp_q.push_back(ev);
    endtask

    task automatic model_byte(input logic [7:0] b, input int acc);
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin m_rs = 4'h0; m_have = 0; return; end
        if (b[7]) begin m_rs = b[7:4]; m_ch = b[3:0]; m_have = 0; return; end
        if (m_rs == 4'h0 || m_rs == 4'hC || m_rs == 4'hD) return;
        if (!m_have) begin m_d1 = b[6:0]; m_have = 1; return; end
        m_have = 0;
        model_msg(m_rs, m_ch, m_d1, b[6:0], acc);
    endtask

    // Per-cycle comparison of every pulse, plus fields on expected events.
    initial begin
        forever begin
            @(negedge clk96);
            if (chk_en) begin
                cmp_got  = {note_pressed, note_released, note_keypress, pitch_wheel,
                            voices_exhausted, free_overflow};
                cmp_want = '0;
                cmp_have = 0;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    cmp_ev   = exp_q.pop_front();
                    cmp_have = 1;
                    cmp_want = 6'b100000 >> cmp_ev.kind;
                end
                check("pulses", 32'(cmp_got), 32'(cmp_want));
                if (cmp_have && cmp_ev.kind < 4)
                    check("fields", 32'({note, velocity, channel, addr}),
                          32'({cmp_ev.note, cmp_ev.vel, cmp_ev.chan, cmp_ev.addr}));
                if (cmp_got != '0) begin
                    pulse_cnt++;
                    last_vec    = cmp_got;
                    last_cyc    = cyc;
                    last_fields = {note, velocity, channel, addr};
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!byte_ready && n < 5000) begin
            @(posedge clk96); #1;
            n++;
        end
        if (!byte_ready) check("ready_timeout", 32'(byte_ready), 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        if (!byte_ready) return;
        midi_byte = b; midi_byte_valid = 1; last_acc = cyc;
        model_byte(b, cyc);
        @(posedge clk96); #1;
        midi_byte_valid = 0;
    endtask

    task automatic poke_busy(input logic [7:0] b);
        check("busy_ready", 32'(byte_ready), 0);
        midi_byte = b; midi_byte_valid = 1;
        @(posedge clk96); #1;
        midi_byte_valid = 0;
    endtask

    task automatic free_voice(input logic [7:0] a);
        ev_t ev;
        wait_ready();
        voice_free = 1; voice_free_addr = a;
        if (free_q.size() >= NV) begin
            ev.kind = 5; ev.due = cyc + 1; ev.note = '0; ev.vel = '0; ev.chan = '0; ev.addr = '0;
            exp_q.push_back(ev);
        end else free_q.push_back(a);
        @(posedge clk96); #1;
        voice_free = 0;
    endtask

    task automatic settle();
        repeat (5) @(posedge clk96);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk96); #1;
        rst_n = 0;
        model_reset();
        #1 chk_en = 1;
        check("rst_ready", 32'(byte_ready), 0);
        check("rst_fields", 32'({note, velocity, channel, addr}), 0);
        repeat (2) @(posedge clk96);
        #1 rst_n = 1;
        repeat (2047) @(posedge clk96);
        #1 check("init_busy", 32'(byte_ready), 0);
        @(posedge clk96);
        #1 check("init_done", 32'(byte_ready), 1);
    endtask

    initial begin
        rst_n = 1; midi_byte = '0; midi_byte_valid = 0; voice_free = 0; voice_free_addr = '0;
        do_reset();

        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        poke_busy(8'h11);
        settle();
        check("r027_kind", 32'(last_vec), 32'(6'b100000));
        check("r027_fields", 32'(last_fields), 32'({7'h3C, 7'h64, 4'h0, 8'h00}));
        check("r027_latency", last_cyc - last_acc, 3);

        send_byte(8'h3E); send_byte(8'h50); settle();
        check("r028_on", 32'(last_fields), 32'({7'h3E, 7'h50, 4'h0, 8'h01}));
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00); settle();
        check("r028_off_kind", 32'(last_vec), 32'(6'b010000));
        check("r028_off", 32'(last_fields), 32'({7'h3C, 7'h00, 4'h0, 8'h00}));

        pc = pulse_cnt;
        send_byte(8'h91); send_byte(8'h40); send_byte(8'h00); settle();
        check("r029_silent", pulse_cnt - pc, 0);

        send_byte(8'h93); send_byte(8'h20); send_byte(8'hF8); send_byte(8'h7F); settle();
        check("r031_on", 32'(last_fields), 32'({7'h20, 7'h7F, 4'h3, 8'h02}));
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h50); settle();
        check("r031_pitch_kind", 32'(last_vec), 32'(6'b000100));
        check("r031_pitch", 32'(last_fields), 32'({7'h50, 7'h00, 4'h0, 8'h02}));
        check("r031_latency", last_cyc - last_acc, 1);

        pc = pulse_cnt;
        send_byte(8'hC5); send_byte(8'h12);
        send_byte(8'hF0); send_byte(8'h3C); send_byte(8'h40); settle();
        check("discard_silent", pulse_cnt - pc, 0);

        send_byte(8'h93); send_byte(8'h20); send_byte(8'h30); settle();
        check("retrigger", 32'(last_fields), 32'({7'h20, 7'h30, 4'h3, 8'h02}));
        send_byte(8'hA3); send_byte(8'h20); send_byte(8'h55); settle();
        check("poly_kind", 32'(last_vec), 32'(6'b001000));
        check("poly", 32'(last_fields), 32'({7'h20, 7'h55, 4'h3, 8'h02}));

        pc = pulse_cnt;
        send_byte(8'h90); send_byte(8'h30);
        do_reset();
        settle();
        check("r032_silent", pulse_cnt - pc, 0);

        free_voice(8'h05); settle();
        check("overflow", 32'(last_vec), 32'(6'b000001));

        send_byte(8'h90);
        for (int i = 0; i < 128; i++) begin send_byte(8'(i)); send_byte(8'h40); end
        send_byte(8'h91);
        for (int i = 0; i < 128; i++) begin send_byte(8'(i)); send_byte(8'h40); end
        settle();
        check("r030_last_slot", 32'(last_fields), 32'({7'h7F, 7'h40, 4'h1, 8'hFF}));
        send_byte(8'h92); send_byte(8'h10); send_byte(8'h40); settle();
        check("r030_exhausted", 32'(last_vec), 32'(6'b000010));
        free_voice(8'h07);
        send_byte(8'h10); send_byte(8'h40); settle();
        check("r030_reuse_kind", 32'(last_vec), 32'(6'b100000));
        check("r030_reuse", 32'(last_fields), 32'({7'h10, 7'h40, 4'h2, 8'h07}));
        check("pending_events", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/midi_voice_alloc.md
MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 256, meaning the number of voice slots (addr range 0..NUM_VOICES-1).
REQ-002 SHALL have parameter NUM_CHANNELS, default 16, meaning the number of MIDI channels tracked in the note map.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports: clk96 input 1 (system clock), rst_n input 1 (async active-low reset).
REQ-004 Data input ports:
- midi_byte input 8: received MIDI byte.
- midi_byte_valid input 1: one-cycle strobe for midi_byte.
- byte_ready output 1: byte will be accepted this cycle.
REQ-005 Voice-return input ports (from synth data/data_valid):
- voice_free input 1: a voice finished release.
- voice_free_addr input 8: slot of the freed voice.
REQ-006 Event outputs:
- note_pressed output 1, note_released output 1, note_keypress output 1, pitch_wheel output 1: one-cycle event pulses.
- note output 7, velocity output 7, channel output 4: event fields.
- addr output 8: voice slot for the event.
REQ-007 Status outputs: voices_exhausted output 1 (one-cycle pulse, note-on dropped); free_overflow output 1 (one-cycle pulse, return dropped).

Function
REQ-008 Parser:
- Status bytes latch running status: 0x8n note off, 0x9n note on, 0xAn poly pressure, 0xEn pitch bend.
- 0xBn is tracked as 2 data bytes and 0xCn/0xDn as 1 data byte; all three are discarded.
- 0xF0-0xF7 clears running status and data bytes are ignored until the next channel status.
- 0xF8-0xFF are ignored without disturbing parser state.
REQ-009 A 2-byte message SHALL complete on its second data byte; subsequent data bytes reuse running status.
REQ-010 Note on with velocity 0 SHALL be treated as note off.
REQ-011 Note map: a NUM_CHANNELS x 128 entry synchronous RAM holding {valid, slot[7:0]}, addressed {channel, note}.
REQ-012 Free list: a FIFO holding unallocated slots that supports push and pop in the same cycle.
REQ-013 FSM states and transitions:
- INIT -> IDLE once the note map is cleared and the FIFO is loaded.
- IDLE -> LOOKUP on a completed note message.
- LOOKUP -> RESOLVE -> EMIT -> IDLE.
- Pitch bend goes IDLE -> EMIT directly.
REQ-014 byte_ready SHALL be high only in IDLE; a midi_byte_valid while byte_ready is low SHALL be discarded.
REQ-015 Note on resolution:
- If the map entry is valid, reuse its slot (retrigger).
- Else, if the FIFO is non-empty, pop a slot and write {1,slot} to the map.
- Else, emit no event and pulse voices_exhausted in the EMIT cycle.
REQ-016 Note off resolution: if the map entry is valid, emit note_released with its slot and write valid=0; if invalid, emit nothing. The slot is NOT returned to the FIFO here.
REQ-017 Poly pressure resolution: if the map entry is valid, emit note_keypress with its slot and velocity set to the pressure value; if invalid, emit nothing.
REQ-018 Pitch bend: emit pitch_wheel with velocity=LSB and note=MSB; addr is unchanged.
REQ-019 Latency: the event pulse SHALL be registered exactly 3 cycles after the completing byte is accepted (1 cycle for pitch bend).
REQ-020 Output timing:
- note, velocity, channel and addr SHALL be valid in the pulse cycle and hold until the next event.
- Pulses are mutually exclusive.
- Successive pulses are at least 2 cycles apart.
REQ-021 Voice return:
- voice_free pushes voice_free_addr in any state except INIT, concurrently with an FSM pop.
- A push when the FIFO is full SHALL be dropped and pulse free_overflow.

Reset
REQ-022 Reset SHALL set all pulse outputs to 0, note/velocity/channel/addr to 0, byte_ready to 0, running status to cleared, and the FSM to INIT.
REQ-023 INIT SHALL clear all map entries and load slots 0..NUM_VOICES-1 into the FIFO in ascending order, taking max(NUM_CHANNELS*128, NUM_VOICES) cycles; byte_ready rises in the cycle after INIT ends.
REQ-024 Reset asserted mid-operation SHALL abandon any event in progress; no pulse is emitted.

Structure
REQ-025 Package midi_pkg SHALL hold the status nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_PRESS=A, CTRL=B, PROG=C, CHAN_PRESS=D, PITCH=E) and the FSM state enum.
REQ-026 Sub-module voice_free_fifo SHALL be a NUM_VOICES x 8 synchronous FIFO with full/empty and simultaneous push/pop.

Verification
REQ-027 After INIT, send 0x90 0x3C 0x64 -> note_pressed 3 cycles after the last byte, with note=0x3C, velocity=0x64, channel=0, addr=0.
REQ-028 Send 0x3E 0x50 (running status), then 0x80 0x3C 0x00 -> note_pressed addr=1, then note_released addr=0.
REQ-029 Send 0x91 0x40 0x00 for a note never pressed -> no pulse on any output.
REQ-030 Allocate 256 notes, then send a 257th note on -> voices_exhausted pulse; then voice_free with addr=0x07 followed by a note on -> note_pressed with addr=0x07.
REQ-031 Send 0x93 0x20, then 0xF8, then 0x7F -> note_pressed on channel 3 (the realtime byte is transparent); send 0xE0 0x00 0x50 -> pitch_wheel with note=0x50.
REQ-032 Deassert rst_n between the second and third byte of a note on -> no pulse, and INIT reruns.
